// File: rtl/mem_arbiter.sv
// Purpose : two-port (I-cache / D-cache) arbiter in front of a single in-order memory port.
// Latency : a request seen in IDLE is forwarded one cycle later; responses are routed combinationally.
// Backpr. : the granted port's ready follows i_mem_ready; reads stall while MAX_OUT reads are in flight.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_ic_* / i_dc_*                   per-port request (ren, wen, addr, wdata)
//   o_ic_ready / o_dc_ready           request accepted this cycle
//   o_ic_valid/rdata, o_dc_valid/rdata read response to the granted port
//   o_mem_* / i_mem_ready             request towards memory
//   i_mem_valid / i_mem_rdata         in-order memory read response
module mem_arbiter #(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ic_ren,
    input  logic        i_ic_wen,
    input  logic [31:0] i_ic_addr,
    input  logic [31:0] i_ic_wdata,
    output logic        o_ic_ready,
    output logic [31:0] o_ic_rdata,
    output logic        o_ic_valid,
    input  logic        i_dc_ren,
    input  logic        i_dc_wen,
    input  logic [31:0] i_dc_addr,
    input  logic [31:0] i_dc_wdata,
    output logic        o_dc_ready,
    output logic [31:0] o_dc_rdata,
    output logic        o_dc_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic       LG_I   = 1'b0;
    localparam logic       LG_D   = 1'b1;
    localparam logic [2:0] LP_MAX = 3'(MAX_OUT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_gnt;
    logic       w_last_nxt;
    logic [2:0] r_outs;
    logic [2:0] w_outs_nxt;

    logic       w_req_i;
    logic       w_req_d;
    logic       w_full;
    logic       w_rsp;
    logic       w_rd_acc;
    logic       w_gnt_req;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_last_gnt <= LG_I;
            r_outs     <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_gnt <= w_last_nxt;
            r_outs     <= w_outs_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_gnt;
        w_outs_nxt  = r_outs;
        w_gnt_req   = 1'b0;
        w_rd_acc    = 1'b0;
        o_ic_ready  = 1'b0;
        o_dc_ready  = 1'b0;
        o_ic_valid  = 1'b0;
        o_dc_valid  = 1'b0;
        o_ic_rdata  = 32'd0;
        o_dc_rdata  = 32'd0;
        o_mem_addr  = 32'd0;
        o_mem_wdata = 32'd0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;

        w_req_i = i_ic_ren | i_ic_wen;
        w_req_d = i_dc_ren | i_dc_wen;
        w_full  = (r_outs == LP_MAX);
        // A response with nothing in flight is stale (e.g. issued before a reset) and is dropped.
        w_rsp   = i_mem_valid && (r_outs != 3'd0);

        case (r_state)
            IDLE: begin
                if (w_req_i && w_req_d) begin
                    if (r_last_gnt == LG_D) begin
                        w_state_nxt = GNT_I;
                        w_last_nxt  = LG_I;
                    end else begin
                        w_state_nxt = GNT_D;
                        w_last_nxt  = LG_D;
                    end
                end else if (w_req_d) begin
                    w_state_nxt = GNT_D;
                    w_last_nxt  = LG_D;
                end else if (w_req_i) begin
                    w_state_nxt = GNT_I;
                    w_last_nxt  = LG_I;
                end
            end
            GNT_I: begin
                w_gnt_req   = w_req_i;
                o_mem_addr  = i_ic_addr;
                o_mem_wdata = i_ic_wdata;
                o_mem_wen   = i_ic_wen;
                o_mem_ren   = i_ic_ren & ~w_full;
                o_ic_ready  = i_mem_ready & ~(i_ic_ren & w_full);
                o_ic_valid  = w_rsp;
                o_ic_rdata  = w_rsp ? i_mem_rdata : 32'd0;
            end
            GNT_D: begin
                w_gnt_req   = w_req_d;
                o_mem_addr  = i_dc_addr;
                o_mem_wdata = i_dc_wdata;
                o_mem_wen   = i_dc_wen;
                o_mem_ren   = i_dc_ren & ~w_full;
                o_dc_ready  = i_mem_ready & ~(i_dc_ren & w_full);
                o_dc_valid  = w_rsp;
                o_dc_rdata  = w_rsp ? i_mem_rdata : 32'd0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Writes complete on acceptance, so only read accepts touch the counter.
        w_rd_acc = o_mem_ren & i_mem_ready;
        case ({w_rd_acc, w_rsp})
            2'b10:   w_outs_nxt = r_outs + 3'd1;
            2'b01:   w_outs_nxt = r_outs - 3'd1;
            default: w_outs_nxt = r_outs;
        endcase

        // Hold the grant until the port goes quiet and every read it issued has returned,
        // so a multi-word line fill is never interleaved with the other port.
        if ((r_state != IDLE) && !w_gnt_req && (w_outs_nxt == 3'd0)) begin
            w_state_nxt = IDLE;
        end

        // Outputs are forced quiet while reset is asserted, whatever the old state was.
        if (i_rst) begin
            o_ic_ready  = 1'b0;
            o_dc_ready  = 1'b0;
            o_ic_valid  = 1'b0;
            o_dc_valid  = 1'b0;
            o_ic_rdata  = 32'd0;
            o_dc_rdata  = 32'd0;
            o_mem_addr  = 32'd0;
            o_mem_wdata = 32'd0;
            o_mem_ren   = 1'b0;
            o_mem_wen   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed bench for mem_arbiter with a response scoreboard.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled mid-cycle.
// Backpr. : the bench plays the memory and drives i_mem_ready / i_mem_valid directly.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_ic_ren, i_ic_wen, i_dc_ren, i_dc_wen;
    logic [31:0] i_ic_addr, i_ic_wdata, i_dc_addr, i_dc_wdata;
    logic        o_ic_ready, o_ic_valid, o_dc_ready, o_dc_valid;
    logic [31:0] o_ic_rdata, o_dc_rdata;
    logic        i_mem_ready, i_mem_valid;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        o_mem_ren, o_mem_wen;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.MAX_OUT(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ic_ren    (i_ic_ren),
        .i_ic_wen    (i_ic_wen),
        .i_ic_addr   (i_ic_addr),
        .i_ic_wdata  (i_ic_wdata),
        .o_ic_ready  (o_ic_ready),
        .o_ic_rdata  (o_ic_rdata),
        .o_ic_valid  (o_ic_valid),
        .i_dc_ren    (i_dc_ren),
        .i_dc_wen    (i_dc_wen),
        .i_dc_addr   (i_dc_addr),
        .i_dc_wdata  (i_dc_wdata),
        .o_dc_ready  (o_dc_ready),
        .o_dc_rdata  (o_dc_rdata),
        .o_dc_valid  (o_dc_valid),
        .i_mem_ready (i_mem_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wen   (o_mem_wen),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_valid (i_mem_valid)
    );

    typedef struct packed {
        logic        port_d;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // A response pushed this cycle must show up on its port this very cycle.
    task automatic monitor();
        logic [1:0] expv;
        rsp_t       e;
        expv = 2'b00;
        e    = '0;
        if (exp_q.size() != 0) begin
            e    = exp_q.pop_front();
            expv = e.port_d ? 2'b01 : 2'b10;
        end
        chk("rsp_valid", {30'd0, o_ic_valid, o_dc_valid}, {30'd0, expv});
        if (expv == 2'b10) chk("ic_rdata", o_ic_rdata, e.data);
        else               chk("ic_rdata_zero", o_ic_rdata, 32'd0);
        if (expv == 2'b01) chk("dc_rdata", o_dc_rdata, e.data);
        else               chk("dc_rdata_zero", o_dc_rdata, 32'd0);
    endtask

    task automatic settle();
        #4;
        monitor();
    endtask

    task automatic adv();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr();
        i_ic_ren = 0; i_ic_wen = 0; i_ic_addr = 0; i_ic_wdata = 0;
        i_dc_ren = 0; i_dc_wen = 0; i_dc_addr = 0; i_dc_wdata = 0;
        i_mem_ready = 0; i_mem_valid = 0; i_mem_rdata = 0;
    endtask

    task automatic push_rsp(input logic port_d, input logic [31:0] d);
        rsp_t e;
        e.port_d    = port_d;
        e.data      = d;
        i_mem_valid = 1;
        i_mem_rdata = d;
        exp_q.push_back(e);
    endtask

    task automatic drop_rsp(input logic [31:0] d);
        i_mem_valid = 1;
        i_mem_rdata = d;
    endtask

    task automatic gnt_chk(input string tag, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic icr, input logic dcr);
        chk({tag, "_ctl"}, {28'd0, o_mem_ren, o_mem_wen, o_ic_ready, o_dc_ready},
            {28'd0, ren, wen, icr, dcr});
        chk({tag, "_addr"}, o_mem_addr, addr);
    endtask

    task automatic zero_chk(input string tag);
        gnt_chk(tag, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk({tag, "_wdata"}, o_mem_wdata, 32'd0);
    endtask

    // With memory ready and no requests, a granted port would see ready high.
    task automatic idle_check(input string tag);
        clr();
        i_mem_ready = 1;
        settle();
        gnt_chk(tag, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        adv();
    endtask

    task automatic do_reset();
        i_rst = 1;
        clr();
        i_ic_ren = 1; i_ic_addr = 32'h0000_0AA0; i_ic_wdata = 32'h1111_1111;
        i_dc_ren = 1; i_dc_addr = 32'h0000_0BB0; i_dc_wdata = 32'h2222_2222;
        i_mem_ready = 1;
        i_mem_valid = 1; i_mem_rdata = 32'h0BAD_0BAD;
        for (int k = 0; k < 2; k++) begin
            settle();
            zero_chk("rst_cycle");
            adv();
        end
        i_rst = 0;
        clr();
        i_mem_ready = 1;
        drop_rsp(32'h0BAD_0001);
        settle();
        zero_chk("post_rst");
        adv();
    endtask

    initial begin
        i_rst = 1;
        clr();
        adv();

        // Single D read, response two cycles after accept.
        do_reset();
        clr(); i_dc_ren = 1; i_dc_addr = 32'h100; i_mem_ready = 1;
        settle(); gnt_chk("A_idle", 0, 0, 32'h0, 0, 0); adv();
        settle(); gnt_chk("A_acc", 1, 0, 32'h100, 0, 1); adv();
        clr();
        settle(); gnt_chk("A_wait", 0, 0, 32'h0, 0, 0); adv();
        clr(); push_rsp(1, 32'hDEAD_BEEF);
        settle(); adv();
        idle_check("A_idle_after");

        // Round robin: D wins the first tie, I follows, D wins the next tie.
        do_reset();
        clr();
        i_ic_ren = 1; i_ic_addr = 32'h400;
        i_dc_ren = 1; i_dc_addr = 32'h500; i_mem_ready = 1;
        settle(); gnt_chk("B_tie_idle", 0, 0, 32'h0, 0, 0); adv();
        settle(); gnt_chk("B_gnt_d", 1, 0, 32'h500, 0, 1); adv();
        i_dc_ren = 0; i_dc_addr = 0; push_rsp(1, 32'hD0D0_0001);
        settle(); gnt_chk("B_d_drain", 0, 0, 32'h0, 0, 1); adv();
        i_mem_valid = 0;
        settle(); gnt_chk("B_idle_i", 0, 0, 32'h0, 0, 0); adv();
        settle(); gnt_chk("B_gnt_i", 1, 0, 32'h400, 1, 0); adv();
        clr(); push_rsp(0, 32'h1C1C_0002);
        settle(); adv();
        clr();
        i_ic_ren = 1; i_ic_addr = 32'h404;
        i_dc_ren = 1; i_dc_addr = 32'h504; i_mem_ready = 1;
        settle(); gnt_chk("B_tie2_idle", 0, 0, 32'h0, 0, 0); adv();
        settle(); gnt_chk("B_gnt_d2", 1, 0, 32'h504, 0, 1); adv();
        clr(); push_rsp(1, 32'hD0D0_0003);
        settle(); adv();
        idle_check("B_idle_end");

        // D line fill with I requesting throughout: no I traffic until D is fully done.
        clr(); i_dc_ren = 1; i_dc_addr = 32'h200; i_mem_ready = 1;
        settle(); adv();
        for (int k = 0; k < 4; k++) begin
            i_dc_addr = 32'h200 + 32'(4 * k);
            i_ic_ren = 1; i_ic_addr = 32'h600;
            settle(); gnt_chk($sformatf("C_fill%0d", k), 1, 0, 32'h200 + 32'(4 * k), 0, 1); adv();
        end
        for (int k = 0; k < 4; k++) begin
            clr(); i_ic_ren = 1; i_ic_addr = 32'h600; i_mem_ready = 1;
            push_rsp(1, 32'hC0DE_0000 + 32'(k));
            settle(); gnt_chk($sformatf("C_drain%0d", k), 0, 0, 32'h0, 0, 1); adv();
        end
        i_mem_valid = 0;
        settle(); gnt_chk("C_idle", 0, 0, 32'h0, 0, 0); adv();
        settle(); gnt_chk("C_gnt_i", 1, 0, 32'h600, 1, 0); adv();
        clr(); push_rsp(0, 32'h1C1C_0600);
        settle(); adv();
        idle_check("C_idle_end");

        // Outstanding limit: fifth read stalls until the first response returns.
        clr(); i_dc_ren = 1; i_dc_addr = 32'h700; i_mem_ready = 1;
        settle(); adv();
        for (int k = 0; k < 4; k++) begin
            i_dc_addr = 32'h700 + 32'(4 * k);
            settle(); gnt_chk($sformatf("D_acc%0d", k), 1, 0, 32'h700 + 32'(4 * k), 0, 1); adv();
        end
        i_dc_addr = 32'h710;
        for (int k = 0; k < 2; k++) begin
            settle(); gnt_chk($sformatf("D_full%0d", k), 0, 0, 32'h710, 0, 0); adv();
        end
        push_rsp(1, 32'hF000_0000);
        settle(); gnt_chk("D_full_rsp", 0, 0, 32'h710, 0, 0); adv();
        i_mem_valid = 0;
        settle(); gnt_chk("D_fifth", 1, 0, 32'h710, 0, 1); adv();
        for (int k = 0; k < 4; k++) begin
            clr(); push_rsp(1, 32'hF000_0001 + 32'(k));
            settle(); adv();
        end
        idle_check("D_idle_end");

        // I write held off by memory for three cycles; no read accounting.
        clr(); i_ic_wen = 1; i_ic_addr = 32'h300; i_ic_wdata = 32'h1234_5678;
        settle(); adv();
        for (int k = 0; k < 3; k++) begin
            settle();
            gnt_chk($sformatf("E_hold%0d", k), 0, 1, 32'h300, 0, 0);
            chk("E_hold_wdata", o_mem_wdata, 32'h1234_5678);
            adv();
        end
        i_mem_ready = 1;
        settle();
        gnt_chk("E_acc", 0, 1, 32'h300, 1, 0);
        chk("E_acc_wdata", o_mem_wdata, 32'h1234_5678);
        adv();
        clr(); i_mem_ready = 1; drop_rsp(32'hBADB_AD00);
        settle(); gnt_chk("E_done", 0, 0, 32'h0, 1, 0); adv();
        idle_check("E_idle_end");

        // Reset with two reads in flight; late responses are dropped.
        clr(); i_dc_ren = 1; i_dc_addr = 32'h800; i_mem_ready = 1;
        settle(); adv();
        for (int k = 0; k < 2; k++) begin
            i_dc_addr = 32'h800 + 32'(4 * k);
            settle(); gnt_chk($sformatf("F_acc%0d", k), 1, 0, 32'h800 + 32'(4 * k), 0, 1); adv();
        end
        do_reset();
        clr(); i_mem_ready = 1; drop_rsp(32'hBAD0_0002);
        settle(); gnt_chk("F_idle", 0, 0, 32'h0, 0, 0); adv();
        // Counter and round-robin pointer must both be back at their reset values.
        clr();
        i_ic_ren = 1; i_ic_addr = 32'h900;
        i_dc_ren = 1; i_dc_addr = 32'h904; i_mem_ready = 1;
        settle(); adv();
        for (int k = 0; k < 4; k++) begin
            i_dc_addr = 32'h904 + 32'(4 * k);
            settle(); gnt_chk($sformatf("F_post%0d", k), 1, 0, 32'h904 + 32'(4 * k), 0, 1); adv();
        end
        for (int k = 0; k < 4; k++) begin
            clr(); push_rsp(1, 32'hAB00_0000 + 32'(k));
            settle(); adv();
        end
        idle_check("F_idle_end");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
